// File: rtl/tof_udp_length_deframer_pkg.sv
// Shared definitions for the TOF UDP length framing: state encodings and the
// byte-length word format agreed between the transmit prepender and this deframer.
package tof_udp_length_deframer_pkg;

  localparam int unsigned AXIS_DATA_W       = 16;
  localparam int unsigned LEN_WORD_SHIFT    = 1;
  localparam int unsigned LEN_FIELD_W       = 10;
  localparam int unsigned MAX_WORDS_DEFAULT = 1024;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  function automatic logic [LEN_FIELD_W-1:0] len_words(input logic [AXIS_DATA_W-1:0] len_bytes);
    return len_bytes[LEN_FIELD_W+LEN_WORD_SHIFT-1:LEN_WORD_SHIFT];
  endfunction

  // A length word must be an even byte count of at least two words, within the
  // payload limit, and must not itself close the frame.
  function automatic logic len_is_legal(input logic [AXIS_DATA_W-1:0] len_bytes,
                                        input logic                   last,
                                        input int unsigned            max_words);
    int unsigned w;
    w = 32'(len_words(len_bytes));
    return (len_bytes[AXIS_DATA_W-1:LEN_FIELD_W+LEN_WORD_SHIFT] == '0) &&
           (len_bytes[LEN_WORD_SHIFT-1:0] == '0) &&
           (w >= 32'd2) && (w <= max_words) && !last;
  endfunction

endpackage

// File: rtl/tof_udp_length_deframer_if.sv
// 16-bit HELIX AXI4-Stream bundle with tuser/tlast, used on both sides of the deframer.
interface tof_udp_length_deframer_if;
  import tof_udp_length_deframer_pkg::*;

  logic [AXIS_DATA_W-1:0] tdata;
  logic                   tvalid;
  logic                   tready;
  logic                   tuser;
  logic                   tlast;

  modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);

endinterface

// File: rtl/tof_udp_length_deframer_out.sv
// Single-stage AXI4-Stream output register; holds its beat until the sink takes it.
module tof_axis_out_reg
  import tof_udp_length_deframer_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_load,
  input  logic [AXIS_DATA_W-1:0] i_tdata,
  input  logic                   i_tuser,
  input  logic                   i_tlast,
  output logic                   o_ready,
  tof_udp_length_deframer_if.master m_axis
);

  logic                   r_valid;
  logic [AXIS_DATA_W-1:0] r_tdata;
  logic                   r_tuser;
  logic                   r_tlast;

  // i_load is only raised while o_ready is high, so a new beat never overwrites a stalled one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_tdata <= '0;
      r_tuser <= 1'b0;
      r_tlast <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_tdata <= i_tdata;
      r_tuser <= i_tuser;
      r_tlast <= i_tlast;
    end else if (m_axis.tready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_ready       = !r_valid || m_axis.tready;
  assign m_axis.tvalid = r_valid;
  assign m_axis.tdata  = r_tdata;
  assign m_axis.tuser  = r_tuser;
  assign m_axis.tlast  = r_tlast;

endmodule

// File: rtl/tof_udp_length_deframer.sv
// Strips the byte-length header from a 16-bit ingress stream, regenerates tlast from it,
// and drops or truncates inconsistent frames while counting them.
module tof_udp_length_deframer
  import tof_udp_length_deframer_pkg::*;
#(
  parameter int unsigned MAX_WORDS = MAX_WORDS_DEFAULT,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 s_axis_aclk,
  input  logic                 s_axis_aresetn,
  tof_udp_length_deframer_if.slave  s_axis,
  tof_udp_length_deframer_if.master m_axis,
  output logic [CNT_WIDTH-1:0] pkt_count,
  output logic [CNT_WIDTH-1:0] len_err_count,
  output logic [CNT_WIDTH-1:0] frame_err_count,
  output logic                 err_pulse
);

  localparam int unsigned REM_W = $clog2(MAX_WORDS + 1);

  state_t               r_state;
  logic [REM_W-1:0]     r_remaining;
  logic                 r_first;
  logic [CNT_WIDTH-1:0] r_pkt_count;
  logic [CNT_WIDTH-1:0] r_len_err_count;
  logic [CNT_WIDTH-1:0] r_frame_err_count;
  logic                 r_err_pulse;

  state_t w_next_state;
  logic   w_accept;
  logic   w_out_ready;
  logic   w_emit;
  logic   w_emit_tlast;
  logic   w_load_len;
  logic   w_pkt_inc;
  logic   w_len_err;
  logic   w_frame_err;
  logic   w_rem_one;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v, input logic en);
    return (en && (v != '1)) ? v + 1'b1 : v;
  endfunction

  assign s_axis.tready = (r_state == ST_DISCARD) ? 1'b1 : w_out_ready;
  assign w_accept      = s_axis.tvalid && s_axis.tready;
  assign w_rem_one     = (r_remaining == REM_W'(1));
  assign w_emit_tlast  = w_rem_one || s_axis.tlast;

  always_comb begin
    w_next_state = r_state;
    w_emit       = 1'b0;
    w_load_len   = 1'b0;
    w_pkt_inc    = 1'b0;
    w_len_err    = 1'b0;
    w_frame_err  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (s_axis.tuser && len_is_legal(s_axis.tdata, s_axis.tlast, MAX_WORDS)) begin
            w_load_len   = 1'b1;
            w_next_state = ST_PAYLOAD;
          end else begin
            w_len_err    = s_axis.tuser;
            w_frame_err  = !s_axis.tuser;
            w_next_state = s_axis.tlast ? ST_IDLE : ST_DISCARD;
          end
        end
      end
      // In payload every accepted word is data; tuser is deliberately ignored here.
      ST_PAYLOAD: begin
        if (w_accept) begin
          w_emit = 1'b1;
          if (w_rem_one) begin
            w_pkt_inc    = s_axis.tlast;
            w_frame_err  = !s_axis.tlast;
            w_next_state = s_axis.tlast ? ST_IDLE : ST_DISCARD;
          end else if (s_axis.tlast) begin
            w_frame_err  = 1'b1;
            w_next_state = ST_IDLE;
          end
        end
      end
      ST_DISCARD: begin
        if (w_accept && s_axis.tlast) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      r_state           <= ST_IDLE;
      r_remaining       <= '0;
      r_first           <= 1'b0;
      r_pkt_count       <= '0;
      r_len_err_count   <= '0;
      r_frame_err_count <= '0;
      r_err_pulse       <= 1'b0;
    end else begin
      r_state           <= w_next_state;
      r_pkt_count       <= sat_inc(r_pkt_count, w_pkt_inc);
      r_len_err_count   <= sat_inc(r_len_err_count, w_len_err);
      r_frame_err_count <= sat_inc(r_frame_err_count, w_frame_err);
      r_err_pulse       <= w_len_err || w_frame_err;
      if (w_load_len) begin
        r_remaining <= REM_W'(len_words(s_axis.tdata));
        r_first     <= 1'b1;
      end else if (w_emit) begin
        r_remaining <= r_remaining - REM_W'(1);
        r_first     <= 1'b0;
      end
    end
  end

  tof_axis_out_reg u_out_reg (
    .clk     (s_axis_aclk),
    .rst_n   (s_axis_aresetn),
    .i_load  (w_emit),
    .i_tdata (s_axis.tdata),
    .i_tuser (r_first),
    .i_tlast (w_emit_tlast),
    .o_ready (w_out_ready),
    .m_axis  (m_axis)
  );

  assign pkt_count       = r_pkt_count;
  assign len_err_count   = r_len_err_count;
  assign frame_err_count = r_frame_err_count;
  assign err_pulse       = r_err_pulse;

endmodule

// File: tb/tb_tof_udp_length_deframer.sv
// Scoreboard bench for tof_udp_length_deframer: directed packets push expected beats,
// a negedge monitor pops and compares every transferred output beat.
module tb_tof_udp_length_deframer;
  import tof_udp_length_deframer_pkg::*;

  typedef struct packed {
    logic [15:0] d;
    logic        u;
    logic        l;
  } beat_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        mReady = 1'b1;
  logic [15:0] pkt_count;
  logic [15:0] len_err_count;
  logic [15:0] frame_err_count;
  logic        err_pulse;

  tof_udp_length_deframer_if s_if ();
  tof_udp_length_deframer_if m_if ();

  assign m_if.tready = mReady;

  tof_udp_length_deframer #(.MAX_WORDS(1024), .CNT_WIDTH(16)) dut (
    .s_axis_aclk     (clk),
    .s_axis_aresetn  (rst_n),
    .s_axis          (s_if),
    .m_axis          (m_if),
    .pkt_count       (pkt_count),
    .len_err_count   (len_err_count),
    .frame_err_count (frame_err_count),
    .err_pulse       (err_pulse)
  );

  always #5 clk = ~clk;

  beat_t       expQ[$];
  int          checks = 0;
  int          passes = 0;
  int          expPkt = 0;
  int          expLen = 0;
  int          expFrame = 0;
  int          expErr = 0;
  int          errSeen = 0;
  bit          toggleMode = 1'b0;
  int          tIdx = 0;
  logic [3:0]  readyPat = 4'b1001;
  bit          holdActive = 1'b0;
  beat_t       held;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Downstream ready: steady 1, or the 1,0,0,1 stall pattern, changed just after each edge.
  always @(posedge clk) begin
    #1;
    if (toggleMode) begin
      mReady = readyPat[tIdx];
      tIdx   = (tIdx + 1) % 4;
    end else begin
      mReady = 1'b1;
    end
  end

  always @(negedge clk) begin
    beat_t act;
    beat_t exp;
    act = {m_if.tdata, m_if.tuser, m_if.tlast};
    if (err_pulse) errSeen++;
    if (holdActive)
      checkOutput("stall_hold", {13'b0, m_if.tvalid, act}, {13'b0, 1'b1, held});
    holdActive = rst_n && m_if.tvalid && !m_if.tready;
    held       = act;
    if (rst_n && m_if.tvalid && m_if.tready) begin
      if (expQ.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpected_beat: got 0x%0h, expected no beat", act);
      end else begin
        exp = expQ.pop_front();
        checkOutput("beat", {14'b0, act}, {14'b0, exp});
      end
    end
  end

  // Drives one input beat from a negedge and returns at the negedge after it is accepted.
  task automatic applyStimulus(input logic [15:0] d, input logic u, input logic l,
                               input bit expOut, input logic expU, input logic expL);
    bit acc;
    bit done;
    if (expOut) expQ.push_back({d, expU, expL});
    s_if.tdata  = d;
    s_if.tuser  = u;
    s_if.tlast  = l;
    s_if.tvalid = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      acc = s_if.tready;
      @(posedge clk);
      @(negedge clk);
      done = acc;
    end
    s_if.tvalid = 1'b0;
    if (!done) begin
      checks++;
      $display("[TB] FAIL accept_timeout: got no tready, expected accept of 0x%0h", d);
    end
  endtask

  // Words base+i; input tlast at lastAt; first emitN words expected out, tlast expected at expLastAt.
  task automatic sendPayload(input logic [15:0] base, input int n, input int lastAt,
                             input int emitN, input int expLastAt);
    for (int i = 0; i < n; i++)
      applyStimulus(base + 16'(i), 1'b0, (i == lastAt), (i < emitN), (i == 0), (i == expLastAt));
  endtask

  task automatic drainAndCheck(input string tag);
    for (int i = 0; i < 100 && expQ.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    checkOutput({tag, "_drained"},   32'(expQ.size()), 32'd0);
    checkOutput({tag, "_pkt"},       32'(pkt_count), 32'(expPkt));
    checkOutput({tag, "_len_err"},   32'(len_err_count), 32'(expLen));
    checkOutput({tag, "_frame_err"}, 32'(frame_err_count), 32'(expFrame));
    checkOutput({tag, "_err_pulses"}, 32'(errSeen), 32'(expErr));
  endtask

  initial begin
    logic [15:0] t1Words [4];
    logic [15:0] badLen  [3];
    t1Words = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    badLen  = '{16'h0007, 16'h0802, 16'h0002};
    s_if.tdata  = '0;
    s_if.tvalid = 1'b0;
    s_if.tuser  = 1'b0;
    s_if.tlast  = 1'b0;
    #3;
    checkOutput("rst_tvalid", 32'(m_if.tvalid), 32'd0);
    checkOutput("rst_tuser",  32'(m_if.tuser), 32'd0);
    checkOutput("rst_tlast",  32'(m_if.tlast), 32'd0);
    checkOutput("rst_tdata",  32'(m_if.tdata), 32'd0);
    checkOutput("rst_err_pulse", 32'(err_pulse), 32'd0);
    checkOutput("rst_pkt",    32'(pkt_count), 32'd0);
    checkOutput("rst_len_err", 32'(len_err_count), 32'd0);
    checkOutput("rst_frame_err", 32'(frame_err_count), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] basic packet");
    applyStimulus(16'h0008, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(t1Words[i], 1'b0, (i == 3), 1'b1, (i == 0), (i == 3));
      checkOutput("latency", {15'b0, m_if.tvalid, m_if.tdata}, {15'b0, 1'b1, t1Words[i]});
    end
    expPkt = 1;
    drainAndCheck("basic");

    $display("[TB] backpressure");
    toggleMode = 1'b1;
    applyStimulus(16'h0008, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    sendPayload(16'hA001, 4, 3, 4, 3);
    expPkt = 2;
    drainAndCheck("stall");
    toggleMode = 1'b0;
    @(negedge clk);

    $display("[TB] early end");
    applyStimulus(16'h0008, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    sendPayload(16'h5001, 3, 2, 3, 2);
    expFrame = 1; expErr = 1;
    applyStimulus(16'h0004, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    sendPayload(16'h6001, 2, 1, 2, 1);
    expPkt = 3;
    drainAndCheck("early");

    $display("[TB] late end");
    applyStimulus(16'h0004, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    sendPayload(16'h7001, 4, 3, 2, 1);
    expFrame = 2; expErr = 2;
    applyStimulus(16'h0004, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    sendPayload(16'h7101, 2, 1, 2, 1);
    expPkt = 4;
    drainAndCheck("late");

    $display("[TB] illegal lengths");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(badLen[k], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      sendPayload(16'h8001, 3, 2, 0, -1);
    end
    expLen = 3; expErr = 5;
    drainAndCheck("badlen");

    $display("[TB] missing header");
    applyStimulus(16'h9999, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(16'h9998, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    expFrame = 3; expErr = 6;
    applyStimulus(16'h0006, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    sendPayload(16'h9001, 3, 2, 3, 2);
    expPkt = 5;
    drainAndCheck("nohdr");

    $display("[TB] reset mid-payload");
    applyStimulus(16'h0008, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    sendPayload(16'hB001, 2, -1, 2, -1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_tvalid", 32'(m_if.tvalid), 32'd0);
    checkOutput("mid_rst_tlast",  32'(m_if.tlast), 32'd0);
    checkOutput("mid_rst_tdata",  32'(m_if.tdata), 32'd0);
    checkOutput("mid_rst_pkt",    32'(pkt_count), 32'd0);
    checkOutput("mid_rst_frame_err", 32'(frame_err_count), 32'd0);
    checkOutput("mid_rst_len_err", 32'(len_err_count), 32'd0);
    expPkt = 0; expLen = 0; expFrame = 0; expErr = 0; errSeen = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(16'h0004, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    sendPayload(16'hC001, 2, 1, 2, 1);
    expPkt = 1;
    drainAndCheck("postrst");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
